// File: rtl/imem_loader.sv
// Byte-stream program loader: packs MSB-first bytes into 32-bit words, writes them
// to instruction memory from address 0 and releases cpu_hold once the whole program is in.
module imem_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              abort,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_hold
);

    // state | meaning
    // IDLE  | waiting for start; cpu_hold keeps its last value
    // RECV  | accepting bytes of the current word
    // WRITE | one-cycle memory write of the assembled word
    // DONE  | one-cycle completion pulse, processor released
    typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] ONE     = {{ADDR_W{1'b0}}, 1'b1};

    state_t              state, state_nxt;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W-1:0]   word_idx;
    logic [1:0]          byte_cnt;
    logic [31:0]         asm_q;

    logic                xfer, len_ok, last_word;
    logic [31:0]         asm_word;
    logic                byte_ready_nxt, mem_we_nxt, busy_nxt, done_nxt, err_nxt, cpu_hold_nxt;
    logic [ADDR_W-1:0]   mem_addr_nxt;
    logic [31:0]         mem_wdata_nxt;

    assign xfer      = byte_valid && byte_ready;
    assign len_ok    = (len != '0) && (len <= MAX_LEN);
    assign last_word = ({1'b0, word_idx} == (len_q - ONE));
    assign asm_word  = {asm_q[23:0], byte_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            len_q      <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            asm_q      <= '0;
            byte_ready <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            cpu_hold   <= 1'b1;
        end else begin
            state      <= state_nxt;
            byte_ready <= byte_ready_nxt;
            mem_we     <= mem_we_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            err        <= err_nxt;
            cpu_hold   <= cpu_hold_nxt;
            if (state == S_IDLE && state_nxt == S_RECV) begin
                len_q    <= len;
                word_idx <= '0;
                byte_cnt <= '0;
            end
            if (state == S_RECV && xfer && !abort) begin
                asm_q    <= asm_word;
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (state == S_WRITE && state_nxt == S_RECV) begin
                word_idx <= word_idx + ADDR_W'(1);
                byte_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start && len_ok) state_nxt = S_RECV;
            end
            S_RECV: begin
                if (abort)                         state_nxt = S_IDLE;
                else if (xfer && byte_cnt == 2'd3) state_nxt = S_WRITE;
            end
            S_WRITE: begin
                if (abort)          state_nxt = S_IDLE;
                else if (last_word) state_nxt = S_DONE;
                else                state_nxt = S_RECV;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        byte_ready_nxt = (state_nxt == S_RECV);
        mem_we_nxt     = (state_nxt == S_WRITE);
        mem_addr_nxt   = mem_we_nxt ? word_idx : mem_addr;
        mem_wdata_nxt  = mem_we_nxt ? asm_word : mem_wdata;
        busy_nxt       = (state_nxt == S_RECV) || (state_nxt == S_WRITE);
        done_nxt       = (state_nxt == S_DONE);
        err_nxt        = ((state == S_IDLE) && start && !len_ok) ||
                         (((state == S_RECV) || (state == S_WRITE)) && abort);
        cpu_hold_nxt   = cpu_hold;
        if (state == S_IDLE && state_nxt == S_RECV) cpu_hold_nxt = 1'b1;
        if (state_nxt == S_DONE)                    cpu_hold_nxt = 1'b0;
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: start-validation table, directed corner
// sequences and randomized loads scored against an expected list of memory writes.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [8:0]  len = '0;
    logic        abort = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = '0;
    logic        byte_ready, mem_we, busy, done, err, cpu_hold;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;

    imem_loader #(.ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len), .abort(abort),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] a; logic [31:0] d; } wr_t;
    typedef struct { logic [8:0] len; logic exp_err; logic exp_busy; } vec_t;

    wr_t         obs[$];
    logic [31:0] exp_words[$];
    int          done_cnt = 0, err_cnt = 0, ready_viol = 0;
    int          total = 0, passed = 0;

    always @(negedge clk) begin
        if (mem_we) obs.push_back('{mem_addr, mem_wdata});
        if (mem_we && byte_ready) ready_viol++;
        if (done) done_cnt++;
        if (err) err_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_start(input logic [8:0] l);
        start = 1'b1; len = l;
        tick(1);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        byte_valid = 1'b1; byte_data = b;
        while (!byte_ready && n < 200) begin tick(1); n++; end
        if (n >= 200) chk("byte_ready_timeout", {31'd0, byte_ready}, 32'd1);
        tick(1);
        byte_valid = 1'b0;
    endtask

    // Load exp_words; gap = idle cycles after each byte (random 0..gap when rnd).
    task automatic run_load(input int gap, input bit rnd, input bit inject_start);
        int n = exp_words.size();
        pulse_start(9'(n));
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        chk("hold_after_start", {31'd0, cpu_hold}, 32'd1);
        for (int w = 0; w < n; w++) begin
            for (int b = 0; b < 4; b++) begin
                logic [31:0] wd = exp_words[w];
                send_byte(wd[31-8*b -: 8]);
                if (b == 3) begin
                    chk("we_after_4th", {31'd0, mem_we}, 32'd1);
                    chk("addr", {24'd0, mem_addr}, 32'(w));
                    chk("wdata", mem_wdata, exp_words[w]);
                    chk("ready_in_write", {31'd0, byte_ready}, 32'd0);
                    if (w == n - 1) begin
                        tick(1);
                        chk("done_pulse", {31'd0, done}, 32'd1);
                        chk("hold_released", {31'd0, cpu_hold}, 32'd0);
                        chk("busy_at_done", {31'd0, busy}, 32'd0);
                    end
                end
                if (inject_start && w == 0 && b == 0) pulse_start(9'd5);
                tick(rnd ? $urandom_range(0, gap) : gap);
            end
        end
        tick(2);
    endtask

    task automatic check_writes(input string tag);
        chk({tag, "_nwrites"}, 32'(obs.size()), 32'(exp_words.size()));
        for (int i = 0; i < obs.size() && i < exp_words.size(); i++) begin
            chk({tag, "_waddr"}, {24'd0, obs[i].a}, 32'(i));
            chk({tag, "_wdata"}, obs[i].d, exp_words[i]);
        end
    endtask

    initial begin
        vec_t vt[6];
        int d0, e0;
        vt[0] = '{9'd0,   1'b1, 1'b0};
        vt[1] = '{9'd257, 1'b1, 1'b0};
        vt[2] = '{9'd511, 1'b1, 1'b0};
        vt[3] = '{9'd256, 1'b0, 1'b1};
        vt[4] = '{9'd1,   1'b0, 1'b1};
        vt[5] = '{9'd7,   1'b0, 1'b1};

        #12 reset = 1'b1;
        tick(2);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_ready", {31'd0, byte_ready}, 32'd0);
        chk("rst_addr", {24'd0, mem_addr}, 32'd0);

        // start length validation; accepted loads are aborted to get back to IDLE
        for (int i = 0; i < 6; i++) begin
            pulse_start(vt[i].len);
            chk("tbl_err", {31'd0, err}, {31'd0, vt[i].exp_err});
            chk("tbl_busy", {31'd0, busy}, {31'd0, vt[i].exp_busy});
            chk("tbl_ready", {31'd0, byte_ready}, {31'd0, vt[i].exp_busy});
            chk("tbl_hold", {31'd0, cpu_hold}, 32'd1);
            tick(1);
            chk("tbl_err_one_cycle", {31'd0, err}, 32'd0);
            if (vt[i].exp_busy) begin
                abort = 1'b1; tick(1); abort = 1'b0;
                chk("tbl_abort_err", {31'd0, err}, 32'd1);
                tick(1);
            end
        end

        // nominal, then gapped
        obs.delete(); exp_words = '{32'h20010005, 32'h00221820}; d0 = done_cnt;
        run_load(0, 1'b0, 1'b0);
        check_writes("nominal");
        chk("nominal_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("nominal_busy_after", {31'd0, busy}, 32'd0);
        chk("nominal_hold_after", {31'd0, cpu_hold}, 32'd0);

        obs.delete(); d0 = done_cnt;
        run_load(3, 1'b0, 1'b0);
        check_writes("gaps");
        chk("gaps_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("ready_viol", 32'(ready_viol), 32'd0);

        // abort during word 1 together with a valid byte
        obs.delete(); e0 = err_cnt;
        pulse_start(9'd2);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'h55); send_byte(8'h66);
        tick(1);
        byte_valid = 1'b1; byte_data = 8'h77; abort = 1'b1;
        tick(1);
        byte_valid = 1'b0; abort = 1'b0;
        chk("abort_err", {31'd0, err}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_hold", {31'd0, cpu_hold}, 32'd1);
        chk("abort_we", {31'd0, mem_we}, 32'd0);
        tick(4);
        chk("abort_nwrites", 32'(obs.size()), 32'd1);
        chk("abort_err_cnt", 32'(err_cnt - e0), 32'd1);
        obs.delete(); exp_words = '{32'hDEADBEEF};
        run_load(0, 1'b0, 1'b0);
        check_writes("post_abort");

        // asynchronous reset between edges during RECV
        pulse_start(9'd2);
        send_byte(8'hA5); send_byte(8'h5A);
        #3 reset = 1'b0;
        #1;
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_ready", {31'd0, byte_ready}, 32'd0);
        chk("async_hold", {31'd0, cpu_hold}, 32'd1);
        chk("async_wdata", mem_wdata, 32'd0);
        chk("async_addr", {24'd0, mem_addr}, 32'd0);
        tick(1); reset = 1'b1; tick(1);
        obs.delete(); exp_words = '{32'hCAFEF00D};
        run_load(1, 1'b0, 1'b0);
        check_writes("post_reset");

        // start while busy is ignored
        obs.delete(); exp_words = '{32'h01234567}; d0 = done_cnt; e0 = err_cnt;
        run_load(0, 1'b0, 1'b1);
        tick(10);
        check_writes("busy_start");
        chk("busy_start_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("busy_start_no_err", 32'(err_cnt - e0), 32'd0);

        // randomized loads
        for (int t = 0; t < 20; t++) begin
            int n = $urandom_range(1, 6);
            obs.delete(); exp_words.delete(); d0 = done_cnt; e0 = err_cnt;
            for (int w = 0; w < n; w++) exp_words.push_back($urandom);
            run_load(3, 1'b1, 1'b0);
            check_writes("rand");
            chk("rand_done_cnt", 32'(done_cnt - d0), 32'd1);
            chk("rand_err_cnt", 32'(err_cnt - e0), 32'd0);
        end
        chk("final_ready_viol", 32'(ready_viol), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart of the instruction fetch path: receives a program as a byte stream over a valid/ready handshake.
- Assembles bytes into 32-bit instruction words and writes them sequentially into instruction memory from word address 0.
- Holds the processor in reset through `cpu_hold` until a load completes. Sits beside the fetch unit at the top level.

Parameters:
- ADDR_W, 8, instruction-memory word-address width; maximum program is 2**ADDR_W words.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a load; sampled only in IDLE.
- len  input  ADDR_W+1  number of words to load; sampled with start.
- abort  input  1  synchronous cancel of an active load.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  8  program byte; each word is sent MSB byte first.
- byte_ready  output  1  loader accepts a byte this cycle.
- mem_we  output  1  instruction-memory write strobe, one cycle per word.
- mem_addr  output  ADDR_W  word address for the write.
- mem_wdata  output  32  assembled instruction word.
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse when the last word has been written.
- err  output  1  one-cycle pulse on a rejected start or an abort.
- cpu_hold  output  1  high = processor held in reset.

Behaviour:
- All outputs are registered (Moore).
- Asserting reset low clears immediately, mid-load included:
  - state = IDLE
  - byte_ready, mem_we, busy, done, err = 0
  - mem_addr = 0, mem_wdata = 0
  - byte counter = 0, word index = 0
  - cpu_hold = 1
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - start with 1 <= len <= 2**ADDR_W: latch len, word index = 0, byte counter = 0, busy = 1, cpu_hold = 1, go to RECV.
  - start with len = 0 or len > 2**ADDR_W: err pulses the next cycle, remain in IDLE, cpu_hold unchanged.
- RECV:
  - byte_ready = 1.
  - A byte transfers only when byte_valid && byte_ready. On each transfer, shift it into the assembly register ({asm[23:0], byte_data}) and increment the byte counter.
  - byte_valid gaps of any length are allowed; nothing advances without a transfer.
  - On the 4th transfer, go to WRITE.
- WRITE (one cycle):
  - byte_ready = 0, mem_we = 1, mem_addr = word index, mem_wdata = assembled word.
  - Next state: if word index == len-1, go to DONE; otherwise increment the word index, clear the byte counter, and go to RECV.
- DONE (one cycle): done = 1, busy = 0, cpu_hold = 0. Next state is IDLE.
- Timing:
  - 4th byte accepted at edge N: mem_we is high in cycle N+1.
  - For the last word: done is high and cpu_hold falls in cycle N+2.
  - Minimum cost is 5 cycles per word.
- abort in RECV or WRITE:
  - Go to IDLE next cycle; any pending write is suppressed (mem_we stays 0).
  - err pulses, busy = 0, cpu_hold stays 1, because the program is incomplete.
  - abort takes priority over a simultaneous byte transfer.
  - abort in IDLE or DONE is ignored.
- start while busy is ignored, with no err.
- Starting a new load from IDLE after a completed load re-asserts cpu_hold.
- Word index never wraps: len is range-checked at start, so the highest address written is 2**ADDR_W-1.
- mem_addr and mem_wdata hold their last values when mem_we = 0.

Test Plan:
- Nominal load:
  - Stimulus: start, len=2; bytes 20,01,00,05, 00,22,18,20 with byte_valid held high.
  - Required: mem_we cycle 1 with addr 0, data 0x20010005; mem_we cycle 2 with addr 1, data 0x00221820; done pulses once; cpu_hold falls with done; busy low afterward.
- Backpressure and gaps:
  - Stimulus: same load with byte_valid low for 3 cycles between every byte.
  - Required: identical writes; byte_ready = 0 during each WRITE cycle; no byte lost or duplicated.
- Rejected starts (ADDR_W=8):
  - start len=0 -> err pulse, state stays IDLE, cpu_hold = 1.
  - start len=257 -> same.
  - start len=256 -> accepted, busy = 1.
- Abort mid-word:
  - Stimulus: after 2 bytes of word 1, abort high together with byte_valid.
  - Required: no mem_we; err pulse; busy = 0; cpu_hold = 1. A following len=1 load of 0xDEADBEEF writes addr 0.
- Reset mid-operation:
  - Stimulus: drive reset low between edges during RECV.
  - Required: outputs go to reset values immediately without a clock edge; a subsequent load starts again at addr 0.
- Start while busy:
  - Stimulus: start len=5 during an active len=1 load.
  - Required: ignored; only addr 0 written; done pulses once.
